// File: rtl/mem_access_unit.sv
// Data-memory access unit for the RV32 MEM stage: converts loads/stores into a
// gnt/ack bus transaction, stalls the pipeline until completion, flags bad accesses.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [31:0]       rdata_r;
  logic              rdata_valid_r;
  logic              bus_err_r;
  logic              legal_s;
  logic              accept_s;
  logic              misalign_s;
  logic              done_ok_s;
  logic              timeout_s;
  logic              cnt_hit_s;
  logic [35:0]       lanes_s;

  // Write strobes in [35:32], lane-replicated data in [31:0]; loads get no strobes.
  function automatic logic [35:0] store_lanes(input logic we, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] wd);
    logic [3:0]  strb;
    logic [31:0] data;
    case (size)
      2'b00: begin
        data = {4{wd[7:0]}};
        strb = 4'b0001 << off;
      end
      2'b01: begin
        data = {2{wd[15:0]}};
        strb = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data = wd;
        strb = 4'b1111;
      end
    endcase
    if (!we) begin
      strb = 4'b0000;
    end else begin
      strb = strb;
    end
    return {strb, data};
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h00_0000, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Legality of the incoming funct3 and its address alignment.
  always_comb begin
    legal_s = 1'b0;
    case (req_funct3)
      3'b000:  legal_s = 1'b1;
      3'b001:  legal_s = ~req_addr[0];
      3'b010:  legal_s = (req_addr[1:0] == 2'b00);
      3'b100:  legal_s = ~req_we;
      3'b101:  legal_s = ~req_we & ~req_addr[0];
      default: legal_s = 1'b0;
    endcase
  end

  assign cnt_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
  assign lanes_s   = store_lanes(req_we, req_funct3[1:0], req_addr[1:0], req_wdata);

  // Next-state logic; in REQ the timeout beats a late gnt, in WAIT the ack beats the timeout.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    misalign_s = 1'b0;
    done_ok_s  = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid && legal_s) begin
          accept_s = 1'b1;
          state_s  = S_REQ;
        end else if (req_valid) begin
          misalign_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (cnt_hit_s) begin
          timeout_s = 1'b1;
          state_s   = S_DONE;
        end else if (bus_gnt) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          done_ok_s = 1'b1;
          state_s   = S_DONE;
        end else if (cnt_hit_s) begin
          timeout_s = 1'b1;
          state_s   = S_DONE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, request latches, timeout counter and completion results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      we_r          <= 1'b0;
      funct3_r      <= 3'b000;
      addr_r        <= '0;
      wdata_r       <= 32'h0000_0000;
      wstrb_r       <= 4'b0000;
      cnt_r         <= '0;
      rdata_r       <= 32'h0000_0000;
      rdata_valid_r <= 1'b0;
      bus_err_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      rdata_valid_r <= done_ok_s & ~we_r;
      bus_err_r     <= timeout_s;
      if (accept_s) begin
        we_r     <= req_we;
        funct3_r <= req_funct3;
        addr_r   <= req_addr;
        wdata_r  <= lanes_s[31:0];
        wstrb_r  <= lanes_s[35:32];
        cnt_r    <= '0;
      end else if (state_r == S_REQ || state_r == S_WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (done_ok_s && !we_r) begin
        rdata_r <= load_extend(funct3_r, addr_r[1:0], bus_rdata);
      end else if (timeout_s || misalign_s) begin
        rdata_r <= 32'h0000_0000;
      end
    end
  end

  assign stall        = accept_s | (state_r == S_REQ) | (state_r == S_WAIT);
  assign misalign_err = misalign_s;
  assign rdata        = misalign_s ? 32'h0000_0000 : rdata_r;
  assign rdata_valid  = rdata_valid_r;
  assign bus_err      = bus_err_r;
  assign bus_req      = (state_r == S_REQ);
  assign bus_we       = we_r;
  assign bus_addr     = {addr_r[ADDR_W-1:2], 2'b00};
  assign bus_wdata    = wdata_r;
  assign bus_wstrb    = wstrb_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a short timeout so the
// abort path and the ack-on-last-cycle boundary are reachable.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, misalign_err, bus_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_gnt, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rin;
    int          gd;        // REQ cycles before gnt
    int          ad;        // WAIT cycles before ack
    bit          early_ack; // ack without gnt while in REQ
    bit          gnt_ack;   // ack together with gnt
    bit          bad;       // misaligned or illegal
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, input int idx);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    bus_gnt = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    if (v.bad) begin
      chk("misalign_err", idx, 32'(misalign_err), 32'd1);
      chk("bad_stall", idx, 32'(stall), 32'd0);
      chk("bad_rdata", idx, rdata, 32'h0);
      chk("bad_bus_req", idx, 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("bad_bus_req_after", idx, 32'(bus_req), 32'd0);
      chk("misalign_pulse", idx, 32'(misalign_err), 32'd0);
      return;
    end
    chk("idle_stall", idx, 32'(stall), 32'd1);
    chk("idle_misalign", idx, 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    req_addr = 32'hFFFF_FFF3; req_wdata = 32'h5555_5555;
    req_we = ~v.we; req_funct3 = 3'b001;
    for (int i = 0; i < v.gd; i++) begin
      bus_ack = v.early_ack;
      @(negedge clk);
      chk("req_bus_req", idx, 32'(bus_req), 32'd1);
      chk("req_stall", idx, 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    bus_gnt = 1'b1; bus_ack = v.gnt_ack;
    @(negedge clk);
    chk("gnt_bus_req", idx, 32'(bus_req), 32'd1);
    chk("bus_addr", idx, bus_addr, v.exp_addr);
    chk("bus_wdata", idx, bus_wdata, v.exp_wdata);
    chk("bus_wstrb", idx, 32'(bus_wstrb), 32'(v.exp_strb));
    chk("bus_we", idx, 32'(bus_we), 32'(v.we));
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_ack = 1'b0;
    for (int i = 0; i < v.ad; i++) begin
      @(negedge clk);
      chk("wait_bus_req", idx, 32'(bus_req), 32'd0);
      chk("wait_stall", idx, 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    bus_ack = 1'b1; bus_rdata = v.rin;
    @(negedge clk);
    chk("ack_stall", idx, 32'(stall), 32'd1);
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("done_stall", idx, 32'(stall), 32'd0);
    chk("rdata_valid", idx, 32'(rdata_valid), 32'(!v.we));
    chk("done_bus_err", idx, 32'(bus_err), 32'd0);
    if (!v.we) chk("rdata", idx, rdata, v.exp_rdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rdata_valid_pulse", idx, 32'(rdata_valid), 32'd0);
    chk("idle_after_stall", idx, 32'(stall), 32'd0);
    if (!v.we) chk("rdata_hold", idx, rdata, v.exp_rdata);
  endtask

  task automatic chk_reset_values(input int idx);
    chk("rst_stall", idx, 32'(stall), 32'd0);
    chk("rst_bus_req", idx, 32'(bus_req), 32'd0);
    chk("rst_bus_we", idx, 32'(bus_we), 32'd0);
    chk("rst_bus_addr", idx, bus_addr, 32'h0);
    chk("rst_bus_wdata", idx, bus_wdata, 32'h0);
    chk("rst_bus_wstrb", idx, 32'(bus_wstrb), 32'd0);
    chk("rst_rdata", idx, rdata, 32'h0);
    chk("rst_flags", idx, {29'd0, rdata_valid, misalign_err, bus_err}, 32'd0);
  endtask

  initial begin
    //          we    f3      addr          wdata         rin           gd ad ea ga bad exp_rdata     exp_addr      exp_wdata     strb
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h10, 32'h0,         4'b0000};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'h80FF_7F01, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 32'h10, 32'h0,         4'b0000};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,        32'h80FF_7F01, 0, 0, 0, 0, 0, 32'h0000_0080, 32'h10, 32'h0,         4'b0000};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h80FF_7F01, 2, 1, 0, 0, 0, 32'hFFFF_80FF, 32'h00, 32'h0,         4'b0000};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0000, 32'h0,        32'h80FF_7F01, 1, 0, 1, 0, 0, 32'h0000_7F01, 32'h00, 32'h0,         4'b0000};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_0011, 32'h0,        32'h80FF_7F01, 0, 0, 0, 1, 0, 32'h0000_007F, 32'h10, 32'h0,         4'b0000};
    vecs[6]  = '{1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 32'h0,        0, 0, 0, 0, 0, 32'h0,         32'h04, 32'hABCD_ABCD, 4'b1100};
    vecs[7]  = '{1'b1, 3'b000, 32'h0000_0009, 32'h0000_00A5, 32'h0,        1, 2, 0, 0, 0, 32'h0,         32'h08, 32'hA5A5_A5A5, 4'b0010};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_000C, 32'hCAFE_F00D, 32'h0,        0, 1, 0, 0, 0, 32'h0,         32'h0C, 32'hCAFE_F00D, 4'b1111};
    vecs[9]  = '{1'b1, 3'b001, 32'h0000_0000, 32'h0000_5678, 32'h0,        0, 0, 0, 0, 0, 32'h0,         32'h00, 32'h5678_5678, 4'b0011};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_0002, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,         32'h0,  32'h0,         4'b0000};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0001, 32'h0000_1111, 32'h0,        0, 0, 0, 0, 1, 32'h0,         32'h0,  32'h0,         4'b0000};
    vecs[12] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,         32'h0,  32'h0,         4'b0000};
    vecs[13] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_0022, 32'h0,        0, 0, 0, 0, 1, 32'h0,         32'h0,  32'h0,         4'b0000};
    // Ack lands on the final allowed cycle: completion must win over the timeout.
    vecs[14] = '{1'b0, 3'b010, 32'h0000_0024, 32'h0,        32'h0123_4567, 3, 3, 0, 0, 0, 32'h0123_4567, 32'h24, 32'h0,         4'b0000};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus_gnt = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    chk_reset_values(0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) do_access(vecs[i], i);

    // Timeout with gnt held low: bus_err in the cycle after 8 REQ cycles.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(negedge clk);
    chk("to_idle_stall", 100, 32'(stall), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_bus_req", 100 + k, 32'(bus_req), 32'd1);
      chk("to_stall", 100 + k, 32'(stall), 32'd1);
      chk("to_no_err_yet", 100 + k, 32'(bus_err), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_bus_err", 109, 32'(bus_err), 32'd1);
    chk("to_stall_drop", 109, 32'(stall), 32'd0);
    chk("to_bus_req_drop", 109, 32'(bus_req), 32'd0);
    chk("to_rdata_valid", 109, 32'(rdata_valid), 32'd0);
    chk("to_rdata", 109, rdata, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", 110, 32'(bus_err), 32'd0);
    chk("to_idle_stall_after", 110, 32'(stall), 32'd0);

    do_access(vecs[0], 200);

    // Reset while in REQ: bus_req must fall without a clock edge.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h7777_7777;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rq_bus_req_before", 300, 32'(bus_req), 32'd1);
    #2; rst = 1'b0; req_valid = 1'b0;
    #1;
    chk_reset_values(300);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset while in WAIT after a load that left rdata non-zero.
    do_access(vecs[0], 400);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("rw_wait_stall", 401, 32'(stall), 32'd1);
    #2; rst = 1'b0; req_valid = 1'b0;
    #1;
    chk_reset_values(401);
    @(posedge clk); #1;
    rst = 1'b1;
    do_access(vecs[1], 402);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
